// File: rtl/memory_interface_pkg.sv
// Shared definitions for the external memory interface block.
// Holds the cycle state encoding, default parameter values and a small
// helper that sizes the wait-state counter.
package memory_interface_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } memState_t;

  localparam int WIDTH_DEFAULT    = 8;
  localparam int MAX_WAIT_DEFAULT = 15;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/memory_interface_wait_counter.sv
// Wait-state counter: counts cycles spent waiting on memory ready.
// Ports: clk/rst, i_clear (synchronous clear), i_enable (count one cycle),
//        o_terminal (count has reached MAX_WAIT-1; counting stops there).
module wait_counter
  import memory_interface_pkg::*;
#(
  parameter  int MAX_WAIT = MAX_WAIT_DEFAULT,
  localparam int CW       = cnt_width(MAX_WAIT)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_terminal
);

  logic [CW-1:0] r_count;

  assign o_terminal = (r_count == CW'(MAX_WAIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_terminal) begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/memory_interface.sv
// External memory interface: runs one read or write bus cycle per request,
// inserting wait states on ready low and forcing completion after MAX_WAIT.
// Ports: busValue/load*/incAddr/start* from the core, ready/dataIn from
//        memory; address/dataOut/writeEnable to memory; dataLatch, busy,
//        dataValid and timeout back to the core.
module memory_interface
  import memory_interface_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEFAULT,
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] busValue,
  input  logic             loadAddrLow,
  input  logic             loadAddrHigh,
  input  logic             incAddr,
  input  logic             startRead,
  input  logic             startWrite,
  input  logic             ready,
  input  logic [WIDTH-1:0] dataIn,
  output logic [15:0]      address,
  output logic [WIDTH-1:0] dataOut,
  output logic             writeEnable,
  output logic [WIDTH-1:0] dataLatch,
  output logic             busy,
  output logic             dataValid,
  output logic             timeout
);

  memState_t        r_state;
  memState_t        w_next;
  logic [15:0]      r_addr;     // address register seen and updated in IDLE
  logic [15:0]      r_cycAddr;  // address frozen for the cycle in flight
  logic [WIDTH-1:0] r_dataOut;
  logic [WIDTH-1:0] r_dataLatch;
  logic             r_isWrite;
  logic             r_timedOut;
  logic             w_start;
  logic             w_startWrite;
  logic             w_cntClear;
  logic             w_cntEn;
  logic             w_terminal;
  logic             w_timeoutHit;

  // Read wins when both starts are raised together.
  assign w_start      = startRead | startWrite;
  assign w_startWrite = startWrite & ~startRead;

  wait_counter #(.MAX_WAIT(MAX_WAIT)) u_wait_counter (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_cntClear),
    .i_enable  (w_cntEn),
    .o_terminal(w_terminal)
  );

  always_comb begin
    w_next       = r_state;
    w_cntClear   = 1'b0;
    w_cntEn      = 1'b0;
    w_timeoutHit = 1'b0;
    case (r_state)
      IDLE: if (w_start) w_next = ADDR;
      ADDR: begin
        w_next     = WAIT;
        w_cntClear = 1'b1;
      end
      WAIT: begin
        if (ready) begin
          w_next = DONE;
        end else begin
          w_cntEn = 1'b1;
          if (w_terminal) begin
            w_next       = DONE;
            w_timeoutHit = 1'b1;
          end
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_addr      <= 16'h0000;
      r_cycAddr   <= 16'h0000;
      r_dataOut   <= '0;
      r_dataLatch <= '0;
      r_isWrite   <= 1'b0;
      r_timedOut  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE) begin
        if (loadAddrLow)  r_addr[7:0]  <= 8'(busValue);
        if (loadAddrHigh) r_addr[15:8] <= 8'(busValue);
        if (!loadAddrLow && !loadAddrHigh && incAddr) r_addr <= r_addr + 16'd1;
        // Cycle uses the address as it stood before any same-edge update.
        if (w_start) begin
          r_cycAddr  <= r_addr;
          r_isWrite  <= w_startWrite;
          r_timedOut <= 1'b0;
          if (w_startWrite) r_dataOut <= busValue;
        end
      end
      if (r_state == WAIT) begin
        if (ready && !r_isWrite) r_dataLatch <= dataIn;
        if (w_timeoutHit)        r_timedOut  <= 1'b1;
      end
    end
  end

  // Decoded from state so that reset clears them without waiting for a clock.
  assign busy        = (r_state != IDLE);
  assign dataValid   = (r_state == DONE);
  assign timeout     = (r_state == DONE) && r_timedOut;
  assign writeEnable = ((r_state == ADDR) || (r_state == WAIT)) && r_isWrite;
  assign address     = busy ? r_cycAddr : r_addr;
  assign dataOut     = r_dataOut;
  assign dataLatch   = r_dataLatch;

endmodule
